// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state enums and NZCV flag bit positions for the ALU and its arbiter
package alu_pkg;
    typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, AND = 2'b10, ORR = 2'b11} opcode_t;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/alu.sv
// alu: combinational N-bit ADD/SUB/AND/ORR with NZCV flags
//   a_i, b_i      operands
//   alu_control_i opcode
//   result_o      result
//   alu_flags_o   {N,Z,C,V}; C and V are zero for the logic ops
module alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  opcode_t      alu_control_i,
    output logic [N-1:0] result_o,
    output logic [3:0]   alu_flags_o
);
    logic [N:0] sum;
    logic       sub;
    logic       arith;
    always_comb begin
        sub = alu_control_i == SUB;
        arith = alu_control_i == ADD || alu_control_i == SUB;
        // subtraction as a + ~b + 1 so the carry out means "no borrow"
        sum = {1'b0, a_i} + {1'b0, sub ? ~b_i : b_i} + {{N{1'b0}}, sub};
        result_o = alu_control_i == AND ? a_i & b_i :
                   alu_control_i == ORR ? a_i | b_i : sum[N-1:0];
        alu_flags_o = 4'b0000;
        alu_flags_o[FLAG_N] = result_o[N-1];
        alu_flags_o[FLAG_Z] = result_o == '0;
        alu_flags_o[FLAG_C] = arith & sum[N];
        // overflow: effective operand signs agree but the sum sign differs
        alu_flags_o[FLAG_V] = arith & ~(a_i[N-1] ^ b_i[N-1] ^ sub) & (a_i[N-1] ^ sum[N-1]);
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter sharing one alu, with registered operands and response
//   clk_i, rst_i               clock, async active-high reset
//   req_valid_i/req_ready_o    per-requester request handshake
//   req{0,1}_opcode_i/_a_i/_b_i request payloads
//   resp_valid_o/resp_ready_i  per-requester response handshake (one owner at a time)
//   resp_result_o/resp_flags_o registered alu result and {N,Z,C,V}
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [1:0]   req_valid_i,
    output logic [1:0]   req_ready_o,
    input  logic [1:0]   req0_opcode_i,
    input  logic [1:0]   req1_opcode_i,
    input  logic [N-1:0] req0_a_i,
    input  logic [N-1:0] req1_a_i,
    input  logic [N-1:0] req0_b_i,
    input  logic [N-1:0] req1_b_i,
    output logic [1:0]   resp_valid_o,
    input  logic [1:0]   resp_ready_i,
    output logic [N-1:0] resp_result_o,
    output logic [3:0]   resp_flags_o
);
    state_t       state;
    state_t       next;
    logic         last_grant;
    logic         owner;
    logic         winner;
    opcode_t      op_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;

    alu #(.N(N)) u_alu (
        .a_i          (a_q),
        .b_i          (b_q),
        .alu_control_i(op_q),
        .result_o     (alu_result),
        .alu_flags_o  (alu_flags)
    );

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        req_ready_o = 2'b00;
        resp_valid_o = 2'b00;
        // a lone requester wins outright; on a tie the one not served last wins
        winner = &req_valid_i ? ~last_grant : req_valid_i[1];
        case (state)
            IDLE: if (|req_valid_i && !rst_i) begin
                req_ready_o = winner ? 2'b10 : 2'b01;
                next = EXEC;
            end
            EXEC: next = RESP;
            RESP: begin
                resp_valid_o = owner ? 2'b10 : 2'b01;
                if (resp_ready_i[owner]) next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            last_grant <= 1'b1;
            owner <= 1'b0;
            op_q <= ADD;
            a_q <= '0;
            b_q <= '0;
            resp_result_o <= '0;
            resp_flags_o <= 4'b0000;
        end else begin
            if (|req_ready_o) begin
                owner <= winner;
                op_q <= winner ? opcode_t'(req1_opcode_i) : opcode_t'(req0_opcode_i);
                a_q <= winner ? req1_a_i : req0_a_i;
                b_q <= winner ? req1_b_i : req0_b_i;
            end
            if (state == EXEC) begin
                resp_result_o <= alu_result;
                resp_flags_o <= alu_flags;
            end
            if (|resp_valid_o && resp_ready_i[owner]) last_grant <= owner;
        end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus against a transaction-level model of the arbiter
module tb_alu_arbiter;
    localparam int N = 32;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   vld = 2'b00;
    logic [1:0]   rdy = 2'b00;
    logic [1:0]   op0 = 2'b00;
    logic [1:0]   op1 = 2'b00;
    logic [N-1:0] a0 = '0;
    logic [N-1:0] b0 = '0;
    logic [N-1:0] a1 = '0;
    logic [N-1:0] b1 = '0;
    logic [1:0]   rr;
    logic [1:0]   rv;
    logic [N-1:0] res;
    logic [3:0]   flg;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(vld), .req_ready_o(rr),
        .req0_opcode_i(op0), .req1_opcode_i(op1),
        .req0_a_i(a0), .req1_a_i(a1),
        .req0_b_i(b0), .req1_b_i(b1),
        .resp_valid_o(rv), .resp_ready_i(rdy),
        .resp_result_o(res), .resp_flags_o(flg)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference alu from signed/unsigned arithmetic: returns {result, N, Z, C, V}
    function automatic logic [N+3:0] ref_alu(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint smax = 64'sd2147483647;
        longint smin = -64'sd2147483648;
        longint lim = 64'sd4294967296;
        longint s = 0;
        logic [N-1:0] r;
        logic c = 1'b0;
        logic v = 1'b0;
        case (op)
            2'd0: begin
                r = a + b;
                c = (longint'(a) + longint'(b)) >= lim;
                s = sa + sb;
                v = s > smax || s < smin;
            end
            2'd1: begin
                r = a - b;
                c = a >= b;
                s = sa - sb;
                v = s > smax || s < smin;
            end
            2'd2: r = a & b;
            default: r = a | b;
        endcase
        return {r, r[N-1], r == '0, c, v};
    endfunction

    function automatic logic pick(input logic [1:0] v, input logic l);
        return v == 2'b11 ? !l : v[1];
    endfunction

    logic         busy = 1'b0;
    logic         last = 1'b1;
    logic         own = 1'b0;
    int           cyc = 0;
    int           acc = 0;
    logic [N+3:0] pend = '0;
    logic [N-1:0] m_res = '0;
    logic [3:0]   m_flg = 4'b0000;
    int           grants[$];
    logic [N-1:0] results[$];

    // model: a transaction is accepted at an edge, its result lands one edge later, and it retires on the owner's ready
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            last <= 1'b1;
            m_res <= '0;
            m_flg <= 4'b0000;
            cyc <= 0;
            acc <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!busy) begin
                if (vld != 2'b00) begin
                    own <= pick(vld, last);
                    busy <= 1'b1;
                    acc <= cyc + 1;
                    pend <= pick(vld, last) ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
                end
            end else if (cyc == acc) {m_res, m_flg} <= pend;
            else if (rdy[own]) begin
                busy <= 1'b0;
                last <= own;
            end
        end
    end

    always @(negedge clk) begin
        chk("req_ready", rr, (!rst && !busy && vld != 2'b00) ? (pick(vld, last) ? 2'b10 : 2'b01) : 2'b00);
        chk("resp_valid", rv, (busy && cyc > acc) ? (own ? 2'b10 : 2'b01) : 2'b00);
        chk("resp_result", res, m_res);
        chk("resp_flags", flg, m_flg);
        if (rr != 2'b00) grants.push_back(rr[1] ? 1 : 0);
        if ((rv & rdy) != 2'b00) results.push_back(res);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic op(input int k, input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [N-1:0] er, input logic [3:0] ef);
        if (k == 0) begin
            op0 = o; a0 = a; b0 = b;
        end else begin
            op1 = o; a1 = a; b1 = b;
        end
        vld = k == 0 ? 2'b01 : 2'b10;
        rdy = 2'b11;
        #1 chk("accept", rr, k == 0 ? 2'b01 : 2'b10);
        step();
        vld = 2'b00;
        step();
        #1 chk("op resp_valid", rv, k == 0 ? 2'b01 : 2'b10);
        chk("op result", res, er);
        chk("op flags", flg, ef);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 chk("reset req_ready", rr, 2'b00);
        chk("reset resp_valid", rv, 2'b00);
        chk("reset result", res, 0);
        chk("reset flags", flg, 0);
        step(); step();
        rst = 1'b0;
        step();
        op(0, 2'd0, 1, 10, 11, 4'b0000);
        op(1, 2'd1, 1, 10, 32'hFFFF_FFF7, 4'b1000);
        op(1, 2'd1, 10, 10, 0, 4'b0110);
        op(0, 2'd0, 32'h8000_0000, 32'h8000_0000, 0, 4'b0111);
        op(1, 2'd0, 32'h7FFF_FFFF, 1, 32'h8000_0000, 4'b1001);
        grants.delete();
        results.delete();
        op0 = 2'd2; a0 = 10; b0 = 10;
        op1 = 2'd3; a1 = 10; b1 = 1;
        vld = 2'b11; rdy = 2'b11;
        repeat (12) step();
        vld = 2'b00;
        chk("grant count", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("grant order", grants.size() > i ? grants[i] : -1, i % 2);
            chk("rr result", results.size() > i ? results[i] : '1, i % 2 ? 11 : 10);
        end
        op0 = 2'd0; a0 = 5; b0 = 7;
        vld = 2'b01; rdy = 2'b10;
        step();
        op1 = 2'd1; a1 = 3; b1 = 1; vld = 2'b10;
        step();
        repeat (5) begin
            #1 chk("stall resp_valid", rv, 2'b01);
            chk("stall result", res, 12);
            chk("stall flags", flg, 4'b0000);
            chk("stall req_ready", rr, 2'b00);
            step();
        end
        rdy = 2'b01;
        step();
        #1 chk("req1 after stall", rr, 2'b10);
        rdy = 2'b11;
        step();
        vld = 2'b00;
        step(); step();
        op0 = 2'd3; a0 = 32'hF0; b0 = 32'h0F;
        vld = 2'b01; rdy = 2'b00;
        step();
        vld = 2'b00;
        step();
        #1 chk("held result", res, 32'hFF);
        #3 rst = 1'b1;
        #1 chk("async rst resp_valid", rv, 2'b00);
        chk("async rst result", res, 0);
        chk("async rst flags", flg, 0);
        chk("async rst req_ready", rr, 2'b00);
        step();
        rst = 1'b0;
        step();
        results.delete();
        op1 = 2'd0; a1 = 3; b1 = 4;
        vld = 2'b10; rdy = 2'b11;
        step();
        vld = 2'b00;
        #4 rst = 1'b1;
        #1 chk("exec rst resp_valid", rv, 2'b00);
        step(); step();
        rst = 1'b0;
        op0 = 2'd0; a0 = 1; b0 = 1;
        op1 = 2'd0; a1 = 2; b1 = 2;
        vld = 2'b11;
        #1 chk("tie after reset", rr, 2'b01);
        step();
        vld = 2'b00;
        step();
        #1 chk("post reset resp_valid", rv, 2'b01);
        chk("post reset result", res, 2);
        step(); step();
        chk("responses after reset", results.size(), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
